// File: rtl/inst_fetch_pkg.sv
// Shared state encoding, err bit positions and default fill instruction for
// the instruction fetch/loader front end.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        ERROR = 2'd3
    } fetchState_t;

    localparam int ERR_OVERFLOW = 0;
    localparam int ERR_CHECKSUM = 1;

    localparam logic [7:0] DEFAULT_FILL_INST = 8'h00;

endpackage

// File: rtl/inst_fetch_loader_mem.sv
// Program memory: 2^ADDR_W x 8, one synchronous write port, one
// asynchronous read port, contents are not reset.
module inst_mem
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [7:0]        wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [7:0]        rdData
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/inst_fetch_loader.sv
// Instruction-side front end: loads program memory from a byte stream and holds
// the core in reset until a full program is resident. Define INST_FETCH_CHECKSUM_EN
// to treat the load_last byte as a checksum over the stored program.
module inst_fetch_loader
    import inst_fetch_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] FILL_INST = DEFAULT_FILL_INST
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_start,
    input  logic            load_valid,
    input  logic [7:0]      load_data,
    input  logic            load_last,
    output logic            load_ready,
    input  logic [7:0]      pc,
    output logic [7:0]      instruction,
    output logic            core_reset,
    output logic [ADDR_W:0] prog_len,
    output logic [1:0]      state,
    output logic [1:0]      err
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    // Handshake: a byte transfers on a rising edge where load_valid && load_ready;
    // load_ready depends only on the state register, never on load_valid.
    fetchState_t     stateQ, stateD;
    logic [ADDR_W:0] wptr, progLen;
    logic            errOvf;
    logic            accept, full, doWrite, setOvf;
    logic            enterLoad, enterRun, enterErr;
    logic [7:0]      memData;
    logic [ADDR_W-1:0] pcAddr;

`ifdef INST_FETCH_CHECKSUM_EN
    logic [7:0] sumQ, sumNext;
    logic       errSum, setSum;
    assign sumNext = sumQ + load_data;
`endif

    assign load_ready = (stateQ == LOAD);
    assign accept     = load_valid && load_ready;
    assign full       = (wptr == DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ     <= IDLE;
            core_reset <= 1'b0;
        end else begin
            stateQ     <= stateD;
            core_reset <= (stateD == RUN);
        end
    end

    always_comb begin
        stateD  = stateQ;
        doWrite = 1'b0;
        setOvf  = 1'b0;
`ifdef INST_FETCH_CHECKSUM_EN
        setSum  = 1'b0;
`endif
        case (stateQ)
            IDLE, RUN, ERROR: begin
                if (load_start) stateD = LOAD;
            end
            LOAD: begin
                if (accept) begin
`ifdef INST_FETCH_CHECKSUM_EN
                    // The checksum byte is never stored, so it is legal even when memory is full.
                    if (load_last) begin
                        if (sumNext == 8'h00) begin
                            stateD = RUN;
                        end else begin
                            stateD = ERROR;
                            setSum = 1'b1;
                        end
                    end else if (full) begin
                        stateD = ERROR;
                        setOvf = 1'b1;
                    end else begin
                        doWrite = 1'b1;
                    end
`else
                    if (full) begin
                        stateD = ERROR;
                        setOvf = 1'b1;
                    end else begin
                        doWrite = 1'b1;
                        if (load_last) stateD = RUN;
                    end
`endif
                end
            end
            default: stateD = IDLE;
        endcase
    end

    assign enterLoad = (stateQ != LOAD) && (stateD == LOAD);
    assign enterRun  = (stateQ == LOAD) && (stateD == RUN);
    assign enterErr  = (stateQ != ERROR) && (stateD == ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr    <= '0;
            progLen <= '0;
            errOvf  <= 1'b0;
`ifdef INST_FETCH_CHECKSUM_EN
            sumQ    <= 8'h00;
            errSum  <= 1'b0;
`endif
        end else begin
            if (enterLoad) begin
                wptr   <= '0;
                errOvf <= 1'b0;
`ifdef INST_FETCH_CHECKSUM_EN
                sumQ   <= 8'h00;
                errSum <= 1'b0;
`endif
            end else if (doWrite) begin
                wptr <= wptr + 1'b1;
`ifdef INST_FETCH_CHECKSUM_EN
                sumQ <= sumNext;
`endif
            end
            if (setOvf) errOvf <= 1'b1;
`ifdef INST_FETCH_CHECKSUM_EN
            if (setSum) errSum <= 1'b1;
`endif
            // The old length stays visible through a reload until the new program is complete.
            if (enterRun) begin
                progLen <= doWrite ? (wptr + 1'b1) : wptr;
            end else if (enterErr) begin
                progLen <= '0;
            end
        end
    end

    assign pcAddr = pc[ADDR_W-1:0];

    inst_mem #(.ADDR_W(ADDR_W)) uMem (
        .clk    (clk),
        .wrEn   (doWrite),
        .wrAddr (wptr[ADDR_W-1:0]),
        .wrData (load_data),
        .rdAddr (pcAddr),
        .rdData (memData)
    );

    assign instruction = ((stateQ == RUN) && ({1'b0, pcAddr} < progLen)) ? memData : FILL_INST;
    assign prog_len    = progLen;
    assign state       = stateQ;
`ifdef INST_FETCH_CHECKSUM_EN
    assign err = {errSum, errOvf};
`else
    assign err = {1'b0, errOvf};
`endif

endmodule
